// File: rtl/spi_flash_ctrl.sv
// rtl/spi_flash_ctrl.sv - SPI mode-0 master issuing flash READ (0x03) with streamed byte reads
module spi_flash_ctrl #(
  parameter int CLKDIV = 2
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [1:0]  io_sel,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  output logic        sck,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, CSHI} state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLKDIV - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [5:0]  bits_q;
  logic [39:0] sr_q;
  logic [7:0]  rx_q;
  logic [7:0]  data_q;
  logic [23:0] addr_q;
  logic        busy_q;
  logic        valid_q;
  logic        sck_q;
  logic        cs_n_q;
  logic        restart_q;

  logic        wr_ok;
  logic        start_req;
  logic        next_req;
  logic        end_req;
  logic [39:0] start_word;

  // Commands are only honoured while idle or holding; busy writes vanish.
  assign wr_ok      = io_wr && !busy_q;
  assign start_req  = wr_ok && (io_sel == 2'd1);
  assign next_req   = wr_ok && (io_sel == 2'd2) && (state_q == HOLD);
  assign end_req    = wr_ok && (io_sel == 2'd3);
  assign start_word = {8'h03, addr_q[23:16], io_wdata, 8'h00};

  // The shift word MSB is the MOSI pin, so MOSI is registered and is zero once the address is out.
  assign sck  = sck_q;
  assign cs_n = cs_n_q;
  assign mosi = sr_q[39];

  // Register readback decoded straight from the select lines.
  always_comb begin
    io_rdata = 16'h0000;
    case (io_sel)
      2'd0:    io_rdata = {14'b0, valid_q, busy_q};
      2'd2:    io_rdata = {8'b0, data_q};
      default: io_rdata = 16'h0000;
    endcase
  end

  // Transfer sequencer: register writes, divider, bit shifting and pin generation.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      bits_q    <= 6'd0;
      sr_q      <= 40'd0;
      rx_q      <= 8'd0;
      data_q    <= 8'd0;
      addr_q    <= 24'd0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      restart_q <= 1'b0;
    end else begin
      if (io_wr && io_sel == 2'd0) addr_q[23:16] <= io_wdata[7:0];
      // A completion later in this block overrides the read-clear.
      if (io_rd && io_sel == 2'd2) valid_q <= 1'b0;
      case (state_q)
        IDLE, HOLD: begin
          if (start_req && state_q == IDLE) begin
            addr_q[15:0] <= io_wdata;
            sr_q         <= start_word;
            bits_q       <= 6'd40;
            cs_n_q       <= 1'b0;
            busy_q       <= 1'b1;
            cnt_q        <= DIV_M1;
            state_q      <= SETUP;
          end else if (start_req || end_req) begin
            // START while holding drops CS first, then relaunches from CSHI.
            if (start_req) addr_q[15:0] <= io_wdata;
            restart_q <= start_req;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
            sr_q      <= 40'd0;
            cnt_q     <= DIV_M1;
            state_q   <= CSHI;
          end else if (next_req) begin
            bits_q  <= 6'd8;
            sr_q    <= 40'd0;
            busy_q  <= 1'b1;
            cnt_q   <= DIV_M1;
            state_q <= SHIFT;
          end
        end
        CSHI: begin
          if (cnt_q == 8'd0) begin
            cnt_q <= DIV_M1;
            if (restart_q) begin
              restart_q <= 1'b0;
              sr_q      <= {8'h03, addr_q, 8'h00};
              bits_q    <= 6'd40;
              cs_n_q    <= 1'b0;
              state_q   <= SETUP;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        SETUP: begin
          if (cnt_q == 8'd0) begin
            cnt_q   <= DIV_M1;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        SHIFT: begin
          if (cnt_q == 8'd0) begin
            cnt_q <= DIV_M1;
            if (!sck_q) begin
              sck_q <= 1'b1;
              rx_q  <= {rx_q[6:0], miso};
            end else begin
              sck_q <= 1'b0;
              if (bits_q == 6'd1) begin
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
                data_q  <= rx_q;
                sr_q    <= 40'd0;
                state_q <= HOLD;
              end else begin
                bits_q <= bits_q - 6'd1;
                sr_q   <= {sr_q[38:0], 1'b0};
              end
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// tb/tb_spi_flash_ctrl.sv - self-checking bench for spi_flash_ctrl with a flash read model
`timescale 1ns/1ps
module tb_spi_flash_ctrl;

  localparam int CLKDIV     = 2;
  localparam int START_FALL = 1 + CLKDIV + 80 * CLKDIV;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_wr = 1'b0;
  logic        io_rd = 1'b0;
  logic [1:0]  io_sel = 2'd0;
  logic [15:0] io_wdata = 16'h0000;
  logic [15:0] io_rdata;
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        miso;

  always #5 clk = ~clk;

  spi_flash_ctrl #(.CLKDIV(CLKDIV)) dut (
    .clk(clk), .resetq(resetq), .io_wr(io_wr), .io_rd(io_rd), .io_sel(io_sel),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  // Flash model: data bytes follow the 32 command/address bits; each bit appears after an sck fall.
  logic [63:0] fdata = 64'd0;
  int          fall_cnt = 0;
  always @(negedge sck or posedge cs_n) begin
    if (cs_n) fall_cnt = 0;
    else      fall_cnt = fall_cnt + 1;
  end
  always_comb begin
    miso = 1'b0;
    if (fall_cnt >= 32 && fall_cnt < 96) miso = fdata[95 - fall_cnt];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] wdata;
    logic [63:0] fdata;
    logic [7:0]  exp_data;
    bit          inj;
    int          rd_at;
  } vec_t;

  typedef struct {
    int          rises;
    logic [39:0] mosi;
    int          fall;
    int          cshi;
    logic        valid;
    logic [7:0]  data;
    logic [15:0] old_rdata;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];

  bit         hold_m    = 1'b0;
  logic [7:0] addr_hi_m = 8'h00;
  logic [7:0] data_m    = 8'h00;

  task automatic write_reg(input logic [1:0] sel, input logic [15:0] wd);
    io_sel = sel; io_wdata = wd; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0; io_sel = 2'd0;
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t        e;
    exp_t        got;
    int          fall, rises, cshi, sckbad;
    logic        prev_sck;
    logic [39:0] mon;
    logic [15:0] st, rd;
    e.rises = 0; e.mosi = 40'd0; e.cshi = 0; e.valid = 1'b0;
    e.data = v.exp_data; e.old_rdata = {8'h00, data_m};
    case (v.sel)
      2'd1: begin
        e.rises = 40;
        e.mosi  = {8'h03, addr_hi_m, v.wdata, 8'h00};
        e.fall  = START_FALL + (hold_m ? CLKDIV : 0);
        e.cshi  = hold_m ? CLKDIV : 0;
        e.valid = 1'b1;
        hold_m  = 1'b1;
      end
      2'd2: begin
        e.rises = 8;
        e.fall  = 1 + 16 * CLKDIV;
        e.valid = 1'b1;
      end
      default: begin
        e.fall = 1 + CLKDIV;
        e.cshi = CLKDIV;
        hold_m = 1'b0;
      end
    endcase
    sb.push_back(e);
    fdata = v.fdata; io_sel = v.sel; io_wdata = v.wdata; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
    fall = 0; rises = 0; cshi = 0; sckbad = 0; prev_sck = 1'b0; mon = 40'd0; st = 16'h0;
    for (int k = 1; k <= 400 && fall == 0; k++) begin
      io_sel = 2'd0; #1; st = io_rdata;
      if (sck && !prev_sck) begin rises++; mon = {mon[38:0], mosi}; end
      prev_sck = sck;
      if (cs_n && sck) sckbad++;
      if (!st[0]) fall = k;
      else begin
        if (cs_n) cshi++;
        if (v.inj && k >= 60 && k <= 63) begin
          io_wr = 1'b1;
          case (k)
            60:      begin io_sel = 2'd2; io_wdata = 16'h0000; end
            61:      begin io_sel = 2'd3; io_wdata = 16'h0000; end
            62:      begin io_sel = 2'd1; io_wdata = 16'hFFFF; end
            default: begin io_sel = 2'd0; io_wdata = 16'h00FF; addr_hi_m = 8'hFF; end
          endcase
        end
        if (k == v.rd_at) begin
          io_sel = 2'd2; io_rd = 1'b1; #1; rd = io_rdata;
          check({tag, " old_rdata"}, rd, e.old_rdata);
        end
        @(negedge clk);
        io_wr = 1'b0; io_rd = 1'b0;
      end
    end
    got = sb.pop_front();
    check({tag, " busy_fall"}, fall, got.fall);
    check({tag, " rises"}, rises, got.rises);
    check({tag, " mosi"}, mon, got.mosi);
    check({tag, " cs_high"}, cshi, got.cshi);
    check({tag, " sck_while_cs_high"}, sckbad, 0);
    check({tag, " status_at_fall"}, st, {14'b0, got.valid, 1'b0});
    if (got.valid) begin
      io_sel = 2'd2; io_rd = 1'b1; #1;
      check({tag, " data"}, io_rdata, {8'h00, got.data});
      @(negedge clk);
      io_rd = 1'b0; io_sel = 2'd0; #1;
      check({tag, " status_after_read"}, io_rdata, 16'h0000);
      data_m = got.data;
    end
  endtask

  initial begin
    int          rises;
    logic        prev;
    bit          bad;
    vecs[0]  = '{2'd1, 16'h2345, 64'hA53C_0000_0000_0000, 8'hA5, 1'b0, -1};
    vecs[1]  = '{2'd2, 16'h0000, 64'hA53C_0000_0000_0000, 8'h3C, 1'b0, -1};
    vecs[2]  = '{2'd1, 16'h0000, 64'h5A00_0000_0000_0000, 8'h5A, 1'b0, -1};
    vecs[3]  = '{2'd3, 16'h0000, 64'h0,                   8'h00, 1'b0, -1};
    vecs[4]  = '{2'd1, 16'h0001, 64'hC381_0000_0000_0000, 8'hC3, 1'b1, -1};
    vecs[5]  = '{2'd2, 16'h0000, 64'hC381_0000_0000_0000, 8'h81, 1'b0, -1};
    vecs[6]  = '{2'd3, 16'h0000, 64'h0,                   8'h00, 1'b0, -1};
    vecs[7]  = '{2'd1, 16'h0002, 64'h7E00_0000_0000_0000, 8'h7E, 1'b0, START_FALL - 1};
    vecs[8]  = '{2'd3, 16'h0000, 64'h0,                   8'h00, 1'b0, -1};
    vecs[9]  = '{2'd1, 16'h00AA, 64'h9900_0000_0000_0000, 8'h99, 1'b0, -1};
    vecs[10] = '{2'd3, 16'h0000, 64'h0,                   8'h00, 1'b0, -1};

    repeat (3) @(negedge clk);
    resetq = 1'b1;
    @(negedge clk); #1;
    check("reset cs_n", cs_n, 1'b1);
    check("reset sck", sck, 1'b0);
    check("reset mosi", mosi, 1'b0);
    io_sel = 2'd0; #1; check("reset status", io_rdata, 16'h0000);
    io_sel = 2'd2; #1; check("reset data", io_rdata, 16'h0000);

    write_reg(2'd0, 16'h0001);
    addr_hi_m = 8'h01;
    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // NEXT while idle must do nothing.
    write_reg(2'd2, 16'h0000);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!cs_n || sck) bad = 1'b1;
      @(negedge clk); #1;
    end
    check("next_idle pins", bad, 1'b0);
    io_sel = 2'd0; #1; check("next_idle status", io_rdata, 16'h0000);

    // Reset mid-SHIFT while sck is high.
    fdata = 64'd0; io_sel = 2'd1; io_wdata = 16'h1234; io_wr = 1'b1;
    @(negedge clk); io_wr = 1'b0;
    rises = 0; prev = 1'b0;
    for (int k = 0; k < 400 && rises < 10; k++) begin
      #1;
      if (sck && !prev) rises++;
      prev = sck;
      if (rises < 10) @(negedge clk);
    end
    check("abort rises_reached", rises, 10);
    check("abort sck_high_before", sck, 1'b1);
    resetq = 1'b0; #1;
    check("abort cs_n", cs_n, 1'b1);
    check("abort sck", sck, 1'b0);
    @(negedge clk);
    resetq = 1'b1; #1;
    io_sel = 2'd0; #1; check("abort status", io_rdata, 16'h0000);
    io_sel = 2'd2; #1; check("abort data", io_rdata, 16'h0000);
    io_sel = 2'd0;
    hold_m = 1'b0; addr_hi_m = 8'h00; data_m = 8'h00;
    for (int i = 9; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
